// File: rtl/datapath_bus.sv
// rtl/datapath_bus.sv - shared-bus register datapath with ALU; DATAPATH_MULT_ITER_EN selects iterative multiply
module datapath_bus (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] write_en,
    input  logic [15:0] inc_en,
    input  logic [15:0] clr_en,
    input  logic [3:0]  read_en,
    input  logic [2:0]  alu_op,
    output logic [15:0] z,
    output logic        alu_busy,
    output logic [15:0] im_addr,
    input  logic [15:0] im_rdata,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    output logic        dm_we,
    input  logic [15:0] dm_rdata,
    output logic [15:0] bus
);

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_LSH = 3'd4;

    logic [15:0] pc_q, pc_d, ar_q, ar_d, ir_q, ir_d, ac_q, ac_d, r_q, r_d;
    logic [15:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
    logic        alu_wr;
    logic [15:0] alu_res;

    function automatic logic [15:0] next_reg(input logic clr, input logic wr, input logic inc,
                                             input logic [15:0] bus_v, input logic [15:0] cur);
        logic [15:0] n;
        if (clr)             n = 16'h0000;
        else if (wr && inc)  n = bus_v + 16'd1;
        else if (wr)         n = bus_v;
        else if (inc)        n = cur + 16'd1;
        else                 n = cur;
        return n;
    endfunction

    always_comb begin
        bus = 16'h0000;
        case (read_en)
            4'd1:    bus = pc_q;
            4'd2:    bus = ar_q;
            4'd4:    bus = ir_q;
            4'd5:    bus = ac_q;
            4'd6:    bus = r_q;
            4'd7:    bus = r1_q;
            4'd8:    bus = r2_q;
            4'd9:    bus = r3_q;
            4'd10:   bus = r4_q;
            4'd12:   bus = dm_rdata;
            4'd13:   bus = im_rdata;
            default: bus = 16'h0000;
        endcase
    end

`ifdef DATAPATH_MULT_ITER_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [15:0] prod_step;

    // Shift-add: only the low 16 product bits are ever needed, so everything stays 16 wide.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        alu_wr    = 1'b0;
        alu_res   = 16'h0000;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);
        if (state_q == IDLE) begin
            case (alu_op)
                OP_ADD: begin alu_wr = 1'b1; alu_res = ac_q + r_q; end
                OP_SUB: begin alu_wr = 1'b1; alu_res = ac_q - r_q; end
                OP_LSH: begin alu_wr = 1'b1; alu_res = ac_q << r_q[3:0]; end
                OP_MUL: begin
                    state_d  = MUL;
                    cnt_d    = 5'd0;
                    mcand_d  = ac_q;
                    mplier_d = r_q;
                    prod_d   = 16'h0000;
                end
                default: ;
            endcase
        end else begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                alu_wr  = 1'b1;
                alu_res = prod_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            prod_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign alu_busy = (state_q == MUL);
`else
    logic [31:0] mul_full;

    assign mul_full = ac_q * r_q;

    always_comb begin
        alu_wr  = 1'b0;
        alu_res = 16'h0000;
        case (alu_op)
            OP_ADD: begin alu_wr = 1'b1; alu_res = ac_q + r_q; end
            OP_SUB: begin alu_wr = 1'b1; alu_res = ac_q - r_q; end
            OP_MUL: begin alu_wr = 1'b1; alu_res = mul_full[15:0]; end
            OP_LSH: begin alu_wr = 1'b1; alu_res = ac_q << r_q[3:0]; end
            default: ;
        endcase
    end

    assign alu_busy = 1'b0;
`endif

    always_comb begin
        pc_d = next_reg(clr_en[1],  write_en[1],  inc_en[1],  bus, pc_q);
        ar_d = next_reg(clr_en[2],  write_en[2],  inc_en[2],  bus, ar_q);
        ir_d = next_reg(clr_en[3],  write_en[3],  inc_en[3],  bus, ir_q);
        r_d  = next_reg(clr_en[5],  write_en[5],  inc_en[5],  bus, r_q);
        r4_d = next_reg(clr_en[7],  write_en[7],  inc_en[7],  bus, r4_q);
        r3_d = next_reg(clr_en[8],  write_en[8],  inc_en[8],  bus, r3_q);
        r2_d = next_reg(clr_en[9],  write_en[9],  inc_en[9],  bus, r2_q);
        r1_d = next_reg(clr_en[10], write_en[10], inc_en[10], bus, r1_q);
        // AC: clear beats the ALU, the ALU beats any bus write or increment.
        if (clr_en[4])   ac_d = 16'h0000;
        else if (alu_wr) ac_d = alu_res;
        else             ac_d = next_reg(1'b0, write_en[4], inc_en[4], bus, ac_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 16'h0000;
            ar_q <= 16'h0000;
            ir_q <= 16'h0000;
            ac_q <= 16'h0000;
            r_q  <= 16'h0000;
            r1_q <= 16'h0000;
            r2_q <= 16'h0000;
            r3_q <= 16'h0000;
            r4_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            ar_q <= ar_d;
            ir_q <= ir_d;
            ac_q <= ac_d;
            r_q  <= r_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
            r4_q <= r4_d;
        end
    end

    logic unused_strobes;
    assign unused_strobes = ^{write_en[15:12], write_en[6], write_en[0],
                              inc_en[15:11], inc_en[6], inc_en[0],
                              clr_en[15:11], clr_en[6], clr_en[0]};

    assign z        = {15'h0000, (ac_q == 16'h0000)};
    assign im_addr  = pc_q;
    assign dm_addr  = ar_q;
    assign dm_wdata = bus;
    assign dm_we    = write_en[11];

endmodule

// File: tb/tb_datapath_bus.sv
// tb/tb_datapath_bus.sv - scoreboard bench for datapath_bus
module tb_datapath_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] write_en, inc_en, clr_en;
    logic [3:0]  read_en;
    logic [2:0]  alu_op;
    logic [15:0] z, im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, bus;
    logic        alu_busy, dm_we;

    datapath_bus dut (
        .clk(clk), .rst(rst), .write_en(write_en), .inc_en(inc_en), .clr_en(clr_en),
        .read_en(read_en), .alu_op(alu_op), .z(z), .alu_busy(alu_busy),
        .im_addr(im_addr), .im_rdata(im_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_we(dm_we), .dm_rdata(dm_rdata), .bus(bus)
    );

    always #5 clk = ~clk;

    localparam int S_PC = 0, S_AR = 1, S_IR = 2, S_AC = 3, S_R = 4, S_Z = 5,
                   S_BUS = 6, S_DMWE = 7, S_BUSY = 8, S_DMWD = 9;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_PC:    return im_addr;
            S_AR:    return dm_addr;
            S_IR:    return dut.ir_q;
            S_AC:    return dut.ac_q;
            S_R:     return dut.r_q;
            S_Z:     return z;
            S_BUS:   return bus;
            S_DMWE:  return {15'h0000, dm_we};
            S_BUSY:  return {15'h0000, alu_busy};
            S_DMWD:  return dm_wdata;
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is due at that cycle's falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e   = q.pop_front();
            act = observe(e.sel);
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [15:0] v, input string n);
        exp_t e;
        e.sel = sel; e.exp = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [15:0] we, input logic [15:0] ie, input logic [15:0] ce,
                          input logic [3:0] re, input logic [2:0] op);
        write_en = we; inc_en = ie; clr_en = ce; read_en = re; alu_op = op;
    endtask

    task automatic idle();
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] mask, input logic [15:0] v);
        im_rdata = v;
        set_in(mask, 16'h0, 16'h0, 4'd13, 3'd0);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; im_rdata = 16'h0; dm_rdata = 16'h0;
        idle();
        tick();
        rst = 1'b0;
        expect_v(S_PC, 16'h0, "reset_pc");
        expect_v(S_AR, 16'h0, "reset_ar");
        expect_v(S_AC, 16'h0, "reset_ac");
        expect_v(S_Z, 16'h0001, "reset_z");
        expect_v(S_BUSY, 16'h0, "reset_busy");
        set_in(16'h0800, 16'h0, 16'h0, 4'd0, 3'd0);
        expect_v(S_DMWE, 16'h1, "reset_dm_we");
        tick();
        idle();
        expect_v(S_DMWE, 16'h0, "dm_we_low");

        // Fetch
        im_rdata = 16'h0A05;
        set_in(16'h0008, 16'h0, 16'h0, 4'd13, 3'd0);
        tick();
        set_in(16'h0, 16'h0002, 16'h0, 4'd0, 3'd0);
        expect_v(S_IR, 16'h0A05, "fetch_ir");
        tick();
        idle();
        expect_v(S_PC, 16'h0001, "fetch_pc");

        // Jump: write and inc together loads bus+1
        load(16'h0008, 16'h0010);
        set_in(16'h0002, 16'h0002, 16'h0, 4'd4, 3'd0);
        expect_v(S_BUS, 16'h0010, "jump_bus");
        tick();
        idle();
        expect_v(S_PC, 16'h0011, "jump_pc");

        // Clear priority and wrap
        load(16'h0004, 16'h1234);
        expect_v(S_AR, 16'h1234, "ar_load");
        im_rdata = 16'h5555;
        set_in(16'h0004, 16'h0004, 16'h0004, 4'd13, 3'd0);
        tick();
        idle();
        expect_v(S_AR, 16'h0, "clr_priority");
        load(16'h0002, 16'hFFFF);
        set_in(16'h0, 16'h0002, 16'h0, 4'd0, 3'd0);
        tick();
        idle();
        expect_v(S_PC, 16'h0, "pc_wrap");

        // R1 via bus, unmapped code yields zero
        load(16'h0400, 16'h7777);
        set_in(16'h0, 16'h0, 16'h0, 4'd7, 3'd0);
        expect_v(S_BUS, 16'h7777, "bus_r1");
        tick();
        set_in(16'h0, 16'h0, 16'h0, 4'd3, 3'd0);
        expect_v(S_BUS, 16'h0, "bus_unmapped");
        tick();
        idle();

        // ALU
        load(16'h0030, 16'h0005);
        expect_v(S_Z, 16'h0, "z_nonzero");
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd2);
        tick();
        idle();
        expect_v(S_AC, 16'h0, "sub_ac");
        expect_v(S_Z, 16'h0001, "sub_z");
        load(16'h0020, 16'h0003);
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd4);
        tick();
        idle();
        expect_v(S_AC, 16'h0, "lshift_zero");
        load(16'h0010, 16'h0003);
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd4);
        tick();
        expect_v(S_AC, 16'h0018, "lshift_3");
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd1);
        tick();
        expect_v(S_AC, 16'h001B, "add");
        im_rdata = 16'h9999;
        set_in(16'h0010, 16'h0, 16'h0, 4'd13, 3'd1);
        tick();
        expect_v(S_AC, 16'h001E, "alu_over_write");
        set_in(16'h0, 16'h0, 16'h0010, 4'd0, 3'd1);
        tick();
        idle();
        expect_v(S_AC, 16'h0, "clr_over_alu");

        // Multiply
        load(16'h0010, 16'h0102);
        load(16'h0020, 16'h0300);
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd3);
        tick();
`ifdef DATAPATH_MULT_ITER_EN
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd1);
        for (int i = 0; i < 16; i++) begin
            expect_v(S_BUSY, 16'h1, "mul_busy");
            expect_v(S_AC, 16'h0102, "mul_ac_hold");
            tick();
        end
        idle();
`else
        idle();
`endif
        expect_v(S_BUSY, 16'h0, "mul_done_busy");
        expect_v(S_AC, 16'h0600, "mul_result");
        tick();

        // Reset during multiply: no late write of 3*5
        load(16'h0010, 16'h0003);
        load(16'h0020, 16'h0005);
        set_in(16'h0, 16'h0, 16'h0, 4'd0, 3'd3);
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v(S_BUSY, 16'h0, "abort_busy");
        expect_v(S_AC, 16'h0, "abort_ac");
        for (int i = 0; i < 20; i++) tick();
        expect_v(S_AC, 16'h0, "abort_no_late_write");

        // DM store / load
        load(16'h0010, 16'h00AB);
        load(16'h0004, 16'h0007);
        set_in(16'h0800, 16'h0, 16'h0, 4'd5, 3'd0);
        expect_v(S_DMWE, 16'h1, "store_we");
        expect_v(S_AR, 16'h0007, "store_addr");
        expect_v(S_DMWD, 16'h00AB, "store_wdata");
        tick();
        dm_rdata = 16'h0042;
        set_in(16'h0010, 16'h0, 16'h0, 4'd12, 3'd0);
        tick();
        idle();
        expect_v(S_AC, 16'h0042, "load_ac");

        tick();
        tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/datapath_bus.md
DATAPATH_BUS -- requirements
Module: datapath_bus

Interface
- REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-003 SHALL have port write_en, input, 16 bits: load strobes. Bit map: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1, 11 DM. Bits 0, 6, 12-15 are ignored.
- REQ-004 SHALL have port inc_en, input, 16 bits: increment strobes, same bit map as write_en, with DM excluded.
- REQ-005 SHALL have port clr_en, input, 16 bits: clear strobes, same bit map as write_en, with DM excluded.
- REQ-006 SHALL have port read_en, input, 4 bits: bus source select. 0 zero, 1 PC, 2 AR, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 12 dm_rdata, 13 im_rdata; all other codes give zero.
- REQ-007 SHALL have port alu_op, input, 3 bits: 0 none, 1 add, 2 sub, 3 mult, 4 lshift; codes 5-7 behave as none.
- REQ-008 SHALL have port z, output, 16 bits: z[0] = (AC == 0); z[15:1] = 0.
- REQ-009 SHALL have port alu_busy, output, 1 bit: high while a multiply is in progress.
- REQ-010 SHALL have ports im_addr (output, 16 bits) = PC and im_rdata (input, 16 bits), with combinational read.
- REQ-011 SHALL have ports dm_addr (output, 16 bits) = AR, dm_wdata (output, 16 bits) = bus, dm_we (output, 1 bit) = write_en[11], and dm_rdata (input, 16 bits), with combinational read.
- REQ-012 SHALL have port bus, output, 16 bits: the current value of the internal shared bus.

Function
- REQ-013 The bus SHALL be a combinational multiplexer of the source selected by read_en.
- REQ-014 Per-register update priority each cycle SHALL be, highest first:
  - clr → 0
  - write and inc together → bus+1
  - write → bus
  - inc → reg+1
  - otherwise hold.
- REQ-015 Increments SHALL wrap modulo 2^16 (0xFFFF+1 = 0x0000).
- REQ-016 ALU operand A SHALL be AC and operand B SHALL be R. All results SHALL be truncated to 16 bits.
- REQ-017 alu_op semantics:
  - add: AC ← A+B
  - sub: AC ← A−B (two's-complement wrap)
  - lshift: AC ← A << B[3:0]
  - mult: AC ← low 16 bits of A×B.
- REQ-018 add, sub and lshift SHALL write AC at the same edge that samples alu_op (1-cycle latency).
- REQ-019 ALU write to AC SHALL take priority over write_en[4] in the same cycle. AC clr_en SHALL override the ALU write.
- REQ-020 Multiply FSM states SHALL be IDLE and MUL:
  - IDLE→MUL when alu_op==3; operands latch at this edge.
  - MUL runs 16 shift-add iterations using a 5-bit counter.
  - After the 16th iteration the FSM returns to IDLE, writing AC at that edge.
- REQ-021 alu_busy SHALL be high in MUL. While in MUL, alu_op SHALL be ignored; non-ALU register updates SHALL proceed normally. A bus write to AC during MUL SHALL be overwritten at completion.
- REQ-022 z SHALL be combinational from the registered AC, so it reflects AC the cycle after AC changes.

Reset
- REQ-023 When rst is high at an edge, the block SHALL:
  - clear PC, AR, IR, AC, R and R1-R4 to 0
  - set the FSM to IDLE, zero the counter, and set alu_busy to 0.
- REQ-024 Reset SHALL override all strobes. An in-progress multiply SHALL be aborted with no AC write.
- REQ-025 After reset, z SHALL be 16'h0001 and dm_we SHALL follow write_en directly.

Configuration
- REQ-026 With macro DATAPATH_MULT_ITER_EN defined, multiply SHALL use the iterative FSM (17-cycle occupancy: start edge plus 16 iterations).
- REQ-027 Without DATAPATH_MULT_ITER_EN:
  - mult SHALL complete in 1 cycle, like add.
  - alu_busy SHALL be tied to 0.
  - The FSM and counter SHALL be absent.

Verification
- REQ-028 Fetch scenario:
  - Stimulus: reset; im_rdata=16'h0A05; read_en=13 with write_en=16'h0008 for 1 cycle, then inc_en=16'h0002 for 1 cycle.
  - Required: IR=16'h0A05, PC=1, im_addr=1.
- REQ-029 Jump scenario:
  - Stimulus: IR=16'h0010; read_en=4 with write_en=16'h0002 and inc_en=16'h0002 in the same cycle.
  - Required: PC=16'h0011.
- REQ-030 Clear priority and wrap scenario:
  - Stimulus 1: AR=16'h1234; clr_en, write_en and inc_en all at bit 2 in the same cycle. Required: AR=0.
  - Stimulus 2: PC=16'hFFFF; inc PC. Required: PC=0.
- REQ-031 ALU scenario:
  - Stimulus: AC=5, R=5; alu_op=2.
  - Required: AC=0 next edge; z=16'h0001 in the following cycle.
  - Stimulus: alu_op=4 with R=3.
  - Required: AC unchanged, i.e. 0.
- REQ-032 Multiply scenario (macro defined):
  - Stimulus: AC=16'h0102, R=16'h0300; alu_op=3 for 1 cycle.
  - Required: alu_busy high for 16 cycles; then AC=16'h0600 (low 16 bits of 0x30600).
  - Reset mid-multiply: alu_busy→0 and AC=0 at the next edge, with no late write.
- REQ-033 DM store/load scenario:
  - Stimulus: AC=16'h00AB, AR=7; read_en=5 with write_en bit 11.
  - Required: dm_we=1, dm_addr=7, dm_wdata=16'h00AB.
  - Stimulus: dm_rdata=16'h0042; read_en=12 with write_en bit 4.
  - Required: AC=16'h0042.
